// File: rtl/obi_xbar_demux_ot_if.sv
// rtl/obi_xbar_demux_ot_if.sv - OBI request/response bundle with master and slave views
interface obi_xbar_demux_ot_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    req;
    logic                    we;
    logic [DATA_WIDTH/8-1:0] be;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    gnt;
    logic                    rvalid;
    logic [DATA_WIDTH-1:0]   rdata;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/obi_xbar_demux_ot.sv
// rtl/obi_xbar_demux_ot.sv - 1-to-N OBI demux with outstanding tracking and error slave
module obi_xbar_demux_ot #(
    parameter int unsigned NSLAVE          = 2,
    parameter int unsigned NUM_RULES       = NSLAVE,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter bit          ERR_EN          = 1'b1,
    parameter logic [31:0] ERR_RDATA       = 32'hBADCAB1E,
    localparam int unsigned IDX_W  = (NSLAVE > 1) ? $clog2(NSLAVE) : 1,
    localparam int unsigned RULE_W = IDX_W + 2 * ADDR_WIDTH,
    localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    // each rule is packed as {idx, start_addr, end_addr}
    input  logic [RULE_W-1:0]      addr_map_i [NUM_RULES],
    input  logic [IDX_W-1:0]       default_idx_i,
    obi_xbar_demux_ot_if.slave     master,
    obi_xbar_demux_ot_if.master    slave [NSLAVE],
    output logic                   decode_err_o,
    output logic [CNT_W-1:0]       outstanding_o
);
    localparam int unsigned TGT_W = $clog2(NSLAVE + 1);
    localparam logic [TGT_W-1:0] ERR_IDX = TGT_W'(NSLAVE);

    logic [TGT_W-1:0]      tgt;
    logic [TGT_W-1:0]      cur_q, cur_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  err_rv_q, err_rv_d;
    logic                  tgt_err, issue, gnt, rvalid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [NSLAVE-1:0]     slv_gnt, slv_rvalid;
    logic [DATA_WIDTH-1:0] slv_rdata [NSLAVE];

    // Later rules overwrite earlier ones, so the highest-numbered match wins.
    always_comb begin
        tgt = ERR_EN ? ERR_IDX : TGT_W'(default_idx_i);
        for (int r = 0; r < NUM_RULES; r++) begin
            if (master.addr >= addr_map_i[r][2*ADDR_WIDTH-1:ADDR_WIDTH] &&
                master.addr <  addr_map_i[r][ADDR_WIDTH-1:0]) begin
                tgt = TGT_W'(addr_map_i[r][RULE_W-1:2*ADDR_WIDTH]);
            end
        end
    end

    always_comb begin
        tgt_err = (tgt == ERR_IDX);
        issue   = !rst_i && master.req && (cnt_q < CNT_W'(MAX_OUTSTANDING)) &&
                  ((cnt_q == '0) || (tgt == cur_q));
        gnt     = 1'b0;
        if (issue) begin
            if (tgt_err) begin
                gnt = 1'b1;
            end else begin
                for (int i = 0; i < NSLAVE; i++) begin
                    if (tgt == TGT_W'(i)) gnt = slv_gnt[i];
                end
            end
        end
    end

    // Responses only count when something is in flight; stray rvalids are dropped.
    always_comb begin
        rvalid = 1'b0;
        rdata  = '0;
        if (!rst_i && (cnt_q != '0)) begin
            if (cur_q == ERR_IDX) begin
                rvalid = err_rv_q;
                rdata  = err_rv_q ? DATA_WIDTH'(ERR_RDATA) : '0;
            end else begin
                for (int i = 0; i < NSLAVE; i++) begin
                    if (cur_q == TGT_W'(i)) begin
                        rvalid = slv_rvalid[i];
                        rdata  = slv_rdata[i];
                    end
                end
            end
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        cur_d    = gnt ? tgt : cur_q;
        err_rv_d = gnt && tgt_err;
        case ({gnt, rvalid})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            cur_q    <= '0;
            err_rv_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            cur_q    <= cur_d;
            err_rv_q <= err_rv_d;
        end
    end

    assign master.gnt    = gnt;
    assign master.rvalid = rvalid;
    assign master.rdata  = rdata;
    assign decode_err_o  = gnt && tgt_err;
    assign outstanding_o = rst_i ? '0 : cnt_q;

    for (genvar g = 0; g < NSLAVE; g++) begin : g_slv
        assign slave[g].req   = issue && (tgt == TGT_W'(g));
        assign slave[g].we    = master.we;
        assign slave[g].be    = master.be;
        assign slave[g].addr  = master.addr;
        assign slave[g].wdata = master.wdata;
        assign slv_gnt[g]     = slave[g].gnt;
        assign slv_rvalid[g]  = slave[g].rvalid;
        assign slv_rdata[g]   = slave[g].rdata;
    end
endmodule

// File: tb/tb_obi_xbar_demux_ot.sv
// tb/tb_obi_xbar_demux_ot.sv - directed bench for obi_xbar_demux_ot
module tb_obi_xbar_demux_ot;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 2;
    localparam int NR = 3;
    localparam int RW = 1 + 2 * AW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    obi_xbar_demux_ot_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_bus ();
    obi_xbar_demux_ot_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_bus [NS] ();
    obi_xbar_demux_ot_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m2_bus ();
    obi_xbar_demux_ot_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s2_bus [NS] ();

    logic [RW-1:0] addr_map [NR];
    logic [0:0]    default_idx;
    logic          decode_err, decode_err2;
    logic [2:0]    outstanding, outstanding2;

    int total = 0;
    int bad   = 0;

    obi_xbar_demux_ot #(.NSLAVE(NS), .NUM_RULES(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                        .MAX_OUTSTANDING(4), .ERR_EN(1'b1), .ERR_RDATA(32'hBADCAB1E)) dut (
        .clk_i(clk), .rst_i(rst), .addr_map_i(addr_map), .default_idx_i(default_idx),
        .master(m_bus), .slave(s_bus), .decode_err_o(decode_err), .outstanding_o(outstanding)
    );

    obi_xbar_demux_ot #(.NSLAVE(NS), .NUM_RULES(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                        .MAX_OUTSTANDING(4), .ERR_EN(1'b0), .ERR_RDATA(32'hBADCAB1E)) dut_noerr (
        .clk_i(clk), .rst_i(rst), .addr_map_i(addr_map), .default_idx_i(default_idx),
        .master(m2_bus), .slave(s2_bus), .decode_err_o(decode_err2), .outstanding_o(outstanding2)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic req, input logic we, input logic [31:0] addr);
        m_bus.req   = req;
        m_bus.we    = we;
        m_bus.addr  = addr;
        m_bus.be    = 4'hF;
        m_bus.wdata = addr ^ 32'h5A5A_5A5A;
    endtask

    task automatic set_slv(input logic g0, input logic rv0, input logic [31:0] rd0,
                           input logic g1, input logic rv1, input logic [31:0] rd1);
        s_bus[0].gnt = g0; s_bus[0].rvalid = rv0; s_bus[0].rdata = rd0;
        s_bus[1].gnt = g1; s_bus[1].rvalid = rv1; s_bus[1].rdata = rd1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        addr_map[0] = {1'b0, 32'h0000_0000, 32'h0000_1000};
        addr_map[1] = {1'b1, 32'h0000_1000, 32'h0000_2000};
        addr_map[2] = {1'b0, 32'h0000_1800, 32'h0000_1900};
        default_idx = 1'b1;
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'h0000_0010);
        set_slv(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        m2_bus.req = 1'b1; m2_bus.we = 1'b0; m2_bus.be = 4'hF;
        m2_bus.addr = 32'hFFFF_0000; m2_bus.wdata = 32'h0;
        s2_bus[0].gnt = 1'b0; s2_bus[0].rvalid = 1'b0; s2_bus[0].rdata = 32'h0;
        s2_bus[1].gnt = 1'b0; s2_bus[1].rvalid = 1'b0; s2_bus[1].rdata = 32'h0;

        // reset held three cycles with a pending request
        next_cyc();
        for (int k = 0; k < 3; k++) begin
            settle();
            check_eq("rst_gnt", m_bus.gnt, 1'b0);
            check_eq("rst_s0req", s_bus[0].req, 1'b0);
            check_eq("rst_outstanding", outstanding, 3'd0);
            if (k < 2) next_cyc();
        end
        next_cyc();
        rst = 1'b0;
        settle();
        check_eq("first_gnt", m_bus.gnt, 1'b1);
        check_eq("first_s0req", s_bus[0].req, 1'b1);
        check_eq("first_s1req", s_bus[1].req, 1'b0);
        next_cyc();
        drive(1'b0, 1'b0, 32'h0);
        set_slv(1'b1, 1'b1, 32'h11, 1'b1, 1'b0, 32'h0);
        settle();
        check_eq("first_out", outstanding, 3'd1);
        check_eq("first_rvalid", m_bus.rvalid, 1'b1);
        check_eq("first_rdata", m_bus.rdata, 32'h11);
        next_cyc();
        set_slv(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        settle();
        check_eq("first_drained", outstanding, 3'd0);

        // back-to-back reads filling the outstanding window
        drive(1'b1, 1'b0, 32'h0000_0020);
        for (int k = 0; k < 4; k++) begin
            settle();
            check_eq("pipe_gnt", m_bus.gnt, 1'b1);
            next_cyc();
        end
        settle();
        check_eq("full_out", outstanding, 3'd4);
        check_eq("full_gnt", m_bus.gnt, 1'b0);
        check_eq("full_s0req", s_bus[0].req, 1'b0);
        next_cyc();
        settle();
        check_eq("full_gnt2", m_bus.gnt, 1'b0);
        next_cyc();
        set_slv(1'b1, 1'b1, 32'h60, 1'b1, 1'b0, 32'h0);
        settle();
        check_eq("full_rv", m_bus.rvalid, 1'b1);
        check_eq("full_rv_blocks_gnt", m_bus.gnt, 1'b0);
        check_eq("full_rv_out", outstanding, 3'd4);
        next_cyc();
        set_slv(1'b1, 1'b1, 32'h61, 1'b1, 1'b0, 32'h0);
        settle();
        check_eq("fifth_gnt", m_bus.gnt, 1'b1);
        check_eq("fifth_rdata", m_bus.rdata, 32'h61);
        check_eq("fifth_out", outstanding, 3'd3);
        next_cyc();
        drive(1'b0, 1'b0, 32'h0);
        settle();
        check_eq("simul_unchanged", outstanding, 3'd3);
        next_cyc();
        next_cyc();
        next_cyc();
        set_slv(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        settle();
        check_eq("pipe_drained", outstanding, 3'd0);

        // slave switch must wait for the previous slave to drain
        drive(1'b1, 1'b0, 32'h0000_0030);
        settle();
        check_eq("sw_gnt0", m_bus.gnt, 1'b1);
        next_cyc();
        drive(1'b1, 1'b0, 32'h0000_1010);
        settle();
        check_eq("sw_s1req_held", s_bus[1].req, 1'b0);
        check_eq("sw_gnt_held", m_bus.gnt, 1'b0);
        next_cyc();
        next_cyc();
        set_slv(1'b1, 1'b1, 32'hA0, 1'b1, 1'b0, 32'h0);
        settle();
        check_eq("sw_rdata0", m_bus.rdata, 32'hA0);
        check_eq("sw_s1req_at_rv", s_bus[1].req, 1'b0);
        next_cyc();
        set_slv(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        settle();
        check_eq("sw_s1req", s_bus[1].req, 1'b1);
        check_eq("sw_gnt1", m_bus.gnt, 1'b1);
        next_cyc();
        drive(1'b0, 1'b0, 32'h0);
        set_slv(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hB1);
        settle();
        check_eq("sw_rv1", m_bus.rvalid, 1'b1);
        check_eq("sw_rdata1", m_bus.rdata, 32'hB1);
        next_cyc();
        set_slv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        // address-map boundaries probed with grants withheld
        drive(1'b1, 1'b0, 32'h0000_1000);
        settle();
        check_eq("map_1000_s1", s_bus[1].req, 1'b1);
        check_eq("map_1000_s0", s_bus[0].req, 1'b0);
        drive(1'b1, 1'b0, 32'h0000_0FFC);
        settle();
        check_eq("map_0ffc_s0", s_bus[0].req, 1'b1);
        drive(1'b1, 1'b0, 32'h0000_1800);
        settle();
        check_eq("map_1800_s0", s_bus[0].req, 1'b1);
        check_eq("map_1800_s1", s_bus[1].req, 1'b0);
        drive(1'b0, 1'b0, 32'h0);
        next_cyc();
        set_slv(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

        // unmapped write then three unmapped reads to the error slave
        drive(1'b1, 1'b1, 32'hFFFF_0000);
        settle();
        check_eq("err_gnt", m_bus.gnt, 1'b1);
        check_eq("err_decode", decode_err, 1'b1);
        check_eq("err_s0req", s_bus[0].req, 1'b0);
        check_eq("err_s1req", s_bus[1].req, 1'b0);
        next_cyc();
        drive(1'b1, 1'b0, 32'h0000_2000);
        settle();
        check_eq("err_rv1", m_bus.rvalid, 1'b1);
        check_eq("err_rdata1", m_bus.rdata, 32'hBADCAB1E);
        check_eq("err_gnt_2000", m_bus.gnt, 1'b1);
        check_eq("err_out1", outstanding, 3'd1);
        next_cyc();
        drive(1'b1, 1'b0, 32'hFFFF_0004);
        settle();
        check_eq("err_rv2", m_bus.rvalid, 1'b1);
        next_cyc();
        drive(1'b1, 1'b0, 32'h8000_0000);
        settle();
        check_eq("err_rv3", m_bus.rvalid, 1'b1);
        check_eq("err_out3", outstanding, 3'd1);
        next_cyc();
        drive(1'b0, 1'b0, 32'h0);
        settle();
        check_eq("err_rv4", m_bus.rvalid, 1'b1);
        check_eq("err_decode_idle", decode_err, 1'b0);
        next_cyc();
        settle();
        check_eq("err_rv_done", m_bus.rvalid, 1'b0);
        check_eq("err_out_done", outstanding, 3'd0);

        // stray response with nothing in flight
        set_slv(1'b1, 1'b1, 32'h77, 1'b1, 1'b0, 32'h0);
        settle();
        check_eq("spur_rvalid", m_bus.rvalid, 1'b0);
        check_eq("spur_rdata", m_bus.rdata, 32'h0);
        next_cyc();
        set_slv(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        settle();
        check_eq("spur_out", outstanding, 3'd0);

        // reset mid-transaction drops the late response
        drive(1'b1, 1'b0, 32'h0000_0040);
        settle();
        check_eq("mid_gnt", m_bus.gnt, 1'b1);
        next_cyc();
        drive(1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        settle();
        check_eq("mid_rst_out", outstanding, 3'd0);
        next_cyc();
        rst = 1'b0;
        set_slv(1'b1, 1'b1, 32'h44, 1'b1, 1'b0, 32'h0);
        settle();
        check_eq("mid_late_rv", m_bus.rvalid, 1'b0);
        next_cyc();
        set_slv(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

        // miss routed to default index when the error slave is disabled
        settle();
        check_eq("dflt_s1req", s2_bus[1].req, 1'b1);
        check_eq("dflt_s0req", s2_bus[0].req, 1'b0);
        check_eq("dflt_decode", decode_err2, 1'b0);
        check_eq("dflt_gnt", m2_bus.gnt, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
